// File: rtl/captura_teclas_if.sv
// Key-event handshake between the keypad front end and the lock FSM.
// The master side presents funcao with an iniciar valid; the slave answers with pronto.
interface captura_teclas_if;
  logic       iniciar;
  logic [1:0] funcao;
  logic       pronto;

  modport master (output iniciar, output funcao, input pronto);
  modport slave  (input iniciar, input funcao, output pronto);
endinterface

// File: rtl/captura_teclas.sv
// Polilock keypad front end: synchronise, debounce and edge-detect 4 buttons, queue presses in a FIFO.
// Define CAPTURA_DB_EN to expose the db_ocupacao / db_descartes debug ports and the discard counter.
module captura_teclas #(
  parameter int DEBOUNCE_CICLOS = 50000,
  parameter int FIFO_PROF       = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       botoes,
  captura_teclas_if.master saida
`ifdef CAPTURA_DB_EN
  ,
  output logic [3:0]       db_ocupacao,
  output logic [3:0]       db_descartes
`endif
);

  localparam int CW = $clog2(DEBOUNCE_CICLOS) + 1;
  localparam int AW = $clog2(FIFO_PROF);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CICLOS - 1);

  logic [3:0]    sync1, sync2;
  logic [3:0]    nivel, nivel_ant;
  logic [3:0]    evento;
  logic [CW-1:0] cont [4];

  logic [1:0]    mem [FIFO_PROF];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          vazio, cheio, push, pop, escreve;
  logic [1:0]    codigo;

  // NOTE: every register here uses <= so all flops sample pre-edge values together.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1     <= '0;
      sync2     <= '0;
      nivel     <= '0;
      nivel_ant <= '0;
      evento    <= '0;
      for (int i = 0; i < 4; i++) cont[i] <= '0;
    end else begin
      sync1     <= botoes;
      sync2     <= sync1;
      nivel_ant <= nivel;
      evento    <= nivel & ~nivel_ant;
      // A level change is accepted only after DEBOUNCE_CICLOS consecutive differing samples.
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == nivel[i]) begin
          cont[i] <= '0;
        end else if (cont[i] == CNT_MAX) begin
          nivel[i] <= ~nivel[i];
          cont[i]  <= '0;
        end else begin
          cont[i] <= cont[i] + 1'b1;
        end
      end
    end
  end

  // NOTE: codigo gets a default before the loop so no latch is inferred.
  always_comb begin
    codigo = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (evento[i]) codigo = 2'(i);
    end
  end

  assign push    = |evento;
  assign vazio   = (wr_ptr == rd_ptr);
  assign cheio   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = saida.iniciar & saida.pronto;
  assign escreve = push & (~cheio | pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (escreve) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: the event storage is not reset; funcao is forced to 0 while the FIFO is empty instead.
  always_ff @(posedge clock) begin
    if (escreve) mem[wr_ptr[AW-1:0]] <= codigo;
  end

  assign saida.iniciar = ~vazio;
  assign saida.funcao  = vazio ? 2'd0 : mem[rd_ptr[AW-1:0]];

`ifdef CAPTURA_DB_EN
  logic       multiplo, perdido;
  logic [3:0] descartes, descartes_prox;
  logic [4:0] soma;

  // Simultaneous presses and a full-FIFO drop each count once per cycle.
  assign multiplo = (evento & (evento - 4'd1)) != 4'd0;
  assign perdido  = push & cheio & ~pop;

  always_comb begin
    soma           = 5'(descartes) + 5'(multiplo) + 5'(perdido);
    descartes_prox = (soma > 5'd15) ? 4'd15 : soma[3:0];
  end

  always_ff @(posedge clock) begin
    if (reset) descartes <= '0;
    else       descartes <= descartes_prox;
  end

  assign db_descartes = descartes;
  assign db_ocupacao  = 4'(wr_ptr - rd_ptr);
`endif

endmodule

// File: tb/tb_captura_teclas.sv
// Bench for captura_teclas: directed vector table plus random key activity against a queue-based model.
// Debug-port checks are active when CAPTURA_DB_EN is defined for the whole build.
module tb_captura_teclas;
  localparam int D = 4;
  localparam int P = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] botoes;
  captura_teclas_if bus ();
`ifdef CAPTURA_DB_EN
  logic [3:0] db_ocupacao, db_descartes;
`endif

  captura_teclas #(.DEBOUNCE_CICLOS(D), .FIFO_PROF(P)) dut (
    .clock (clock),
    .reset (reset),
    .botoes(botoes),
    .saida (bus)
`ifdef CAPTURA_DB_EN
    ,
    .db_ocupacao (db_ocupacao),
    .db_descartes(db_descartes)
`endif
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nome, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nome, got, exp, $time);
    end
  endtask

  // Reference model: delay lines for sync and edge detect, sliding window for debounce, queue for FIFO.
  logic [3:0] m_s1, m_s2, m_lvl;
  logic [3:0] m_win [$];
  logic [3:0] m_line [$];
  logic [1:0] m_q [$];
  int         m_desc;

  task automatic model_edge(input logic r, input logic [3:0] b, input logic p);
    logic [3:0] novo, ev;
    logic [1:0] code;
    bit         todos, pop_m, push_m, cheio_m;
    int         disc;
    if (r) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0;
      m_win.delete();
      m_line = '{4'd0, 4'd0};
      m_q.delete();
      m_desc = 0;
      return;
    end
    m_win.push_back(m_s2);
    if (m_win.size() > D) void'(m_win.pop_front());
    novo = m_lvl;
    if (m_win.size() == D) begin
      for (int i = 0; i < 4; i++) begin
        todos = 1'b1;
        foreach (m_win[j]) if (m_win[j][i] == m_lvl[i]) todos = 1'b0;
        if (todos) novo[i] = ~m_lvl[i];
      end
    end
    ev = m_line.pop_front();
    m_line.push_back(novo & ~m_lvl);
    pop_m   = (m_q.size() != 0) && p;
    push_m  = (ev != 4'd0);
    cheio_m = (m_q.size() == P);
    disc = 0;
    if (push_m && $countones(ev) > 1) disc++;
    if (push_m && cheio_m && !pop_m) disc++;
    if (pop_m) void'(m_q.pop_front());
    if (push_m && !(cheio_m && !pop_m)) begin
      code = 2'd0;
      for (int i = 3; i >= 0; i--) if (ev[i]) code = 2'(i);
      m_q.push_back(code);
    end
    m_desc = (m_desc + disc > 15) ? 15 : m_desc + disc;
    m_lvl = novo;
    m_s2  = m_s1;
    m_s1  = b;
  endtask

  task automatic cmp_model();
    check("model.iniciar", 8'(bus.iniciar), 8'(m_q.size() != 0));
    if (m_q.size() != 0) check("model.funcao", 8'(bus.funcao), 8'(m_q[0]));
`ifdef CAPTURA_DB_EN
    check("model.ocupacao", 8'(db_ocupacao), 8'(m_q.size()));
    check("model.descartes", 8'(db_descartes), 8'(m_desc));
`endif
  endtask

  task automatic step(input logic r, input logic [3:0] b, input logic p);
    reset      = r;
    botoes     = b;
    bus.pronto = p;
    @(posedge clock);
    model_edge(r, b, p);
    #1;
    cmp_model();
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] b;
    logic       p;
    int         n;
    logic       e_ini;
    logic [1:0] e_fn;
    logic [3:0] e_occ;
    logic [3:0] e_desc;
  } vec_t;

  vec_t tbl [$];

  function automatic void add(input logic rst, input logic [3:0] b, input logic p, input int n,
                              input logic e_ini, input logic [1:0] e_fn,
                              input logic [3:0] e_occ, input logic [3:0] e_desc);
    vec_t v;
    v = '{rst, b, p, n, e_ini, e_fn, e_occ, e_desc};
    tbl.push_back(v);
  endfunction

  initial begin
    logic [3:0] rb;
    int         len;

    // reset, then key 2 held: one event 8 edges after the change, none while held
    add(1, 4'h0, 1, 2,  0, 0, 0, 0);
    add(0, 4'h4, 1, 7,  0, 0, 0, 0);
    add(0, 4'h4, 1, 1,  1, 2, 1, 0);
    add(0, 4'h4, 1, 1,  0, 0, 0, 0);
    add(0, 4'h4, 1, 12, 0, 0, 0, 0);
    add(0, 4'h0, 1, 8,  0, 0, 0, 0);
    // short glitch on key 1
    add(0, 4'h2, 1, 3,  0, 0, 0, 0);
    add(0, 4'h0, 1, 10, 0, 0, 0, 0);
    // fill with pronto=0: keys 0,1,3,2 then key 1 dropped; drain in order
    add(0, 4'h1, 0, 8,  1, 0, 1, 0);
    add(0, 4'h0, 0, 8,  1, 0, 1, 0);
    add(0, 4'h2, 0, 8,  1, 0, 2, 0);
    add(0, 4'h0, 0, 8,  1, 0, 2, 0);
    add(0, 4'h8, 0, 8,  1, 0, 3, 0);
    add(0, 4'h0, 0, 8,  1, 0, 3, 0);
    add(0, 4'h4, 0, 8,  1, 0, 4, 0);
    add(0, 4'h0, 0, 8,  1, 0, 4, 0);
    add(0, 4'h2, 0, 8,  1, 0, 4, 1);
    add(0, 4'h0, 0, 8,  1, 0, 4, 1);
    add(0, 4'h0, 1, 1,  1, 1, 3, 1);
    add(0, 4'h0, 1, 1,  1, 3, 2, 1);
    add(0, 4'h0, 1, 1,  1, 2, 1, 1);
    add(0, 4'h0, 1, 1,  0, 0, 0, 1);
    // simultaneous rise on keys 1 and 3
    add(1, 4'h0, 1, 1,  0, 0, 0, 0);
    add(0, 4'hA, 1, 8,  1, 1, 1, 1);
    add(0, 4'hA, 1, 1,  0, 0, 0, 1);
    add(0, 4'h0, 1, 8,  0, 0, 0, 1);
    // full FIFO, push and pop in the same cycle
    add(0, 4'h1, 0, 8,  1, 0, 1, 1);
    add(0, 4'h0, 0, 8,  1, 0, 1, 1);
    add(0, 4'h2, 0, 8,  1, 0, 2, 1);
    add(0, 4'h0, 0, 8,  1, 0, 2, 1);
    add(0, 4'h4, 0, 8,  1, 0, 3, 1);
    add(0, 4'h0, 0, 8,  1, 0, 3, 1);
    add(0, 4'h8, 0, 8,  1, 0, 4, 1);
    add(0, 4'h0, 0, 8,  1, 0, 4, 1);
    add(0, 4'h1, 0, 7,  1, 0, 4, 1);
    add(0, 4'h1, 1, 1,  1, 1, 4, 1);
    add(0, 4'h0, 0, 8,  1, 1, 4, 1);
    add(0, 4'h0, 1, 1,  1, 2, 3, 1);
    add(0, 4'h0, 1, 1,  1, 3, 2, 1);
    add(0, 4'h0, 1, 1,  1, 0, 1, 1);
    add(0, 4'h0, 1, 1,  0, 0, 0, 1);
    // reset with 3 events queued
    add(0, 4'h8, 0, 8,  1, 3, 1, 1);
    add(0, 4'h0, 0, 8,  1, 3, 1, 1);
    add(0, 4'h4, 0, 8,  1, 3, 2, 1);
    add(0, 4'h0, 0, 8,  1, 3, 2, 1);
    add(0, 4'h2, 0, 8,  1, 3, 3, 1);
    add(0, 4'h0, 0, 8,  1, 3, 3, 1);
    add(1, 4'h0, 0, 1,  0, 0, 0, 0);
    add(0, 4'h0, 1, 4,  0, 0, 0, 0);
    // key held through reset release gives exactly one press
    add(1, 4'h8, 1, 2,  0, 0, 0, 0);
    add(0, 4'h8, 1, 7,  0, 0, 0, 0);
    add(0, 4'h8, 1, 1,  1, 3, 1, 0);
    add(0, 4'h8, 1, 10, 0, 0, 0, 0);
    add(0, 4'h0, 1, 8,  0, 0, 0, 0);

    foreach (tbl[t]) begin
      for (int c = 0; c < tbl[t].n; c++) step(tbl[t].rst, tbl[t].b, tbl[t].p);
      check($sformatf("vec%0d.iniciar", t), 8'(bus.iniciar), 8'(tbl[t].e_ini));
      if (tbl[t].e_ini || tbl[t].rst)
        check($sformatf("vec%0d.funcao", t), 8'(bus.funcao), 8'(tbl[t].e_fn));
`ifdef CAPTURA_DB_EN
      check($sformatf("vec%0d.ocupacao", t), 8'(db_ocupacao), 8'(tbl[t].e_occ));
      check($sformatf("vec%0d.descartes", t), 8'(db_descartes), 8'(tbl[t].e_desc));
`endif
    end

    // random key activity with random back-pressure and occasional reset
    step(1'b1, 4'h0, 1'b1);
    repeat (160) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: rb = 4'(1 << $urandom_range(0, 3));
        5, 6:          rb = 4'h0;
        default:       rb = 4'($urandom);
      endcase
      len = $urandom_range(1, 14);
      for (int c = 0; c < len; c++) step(1'b0, rb, $urandom_range(0, 3) != 0);
      if ($urandom_range(0, 40) == 0) step(1'b1, rb, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
